// File: rtl/sc_row_clear_ctrl.sv
// Row-clear controller: scans a register matrix bottom-up, collapses every
// full row by shifting the rows above it down, and reports how many were cleared.
module sc_row_clear_ctrl #(
  parameter int NUMBER_DATAWIDTH = 8,
  parameter int NUMBER_ROWS      = 8
) (
  input  logic                                SC_ROW_CLEAR_CTRL_CLOCK_50,
  input  logic                                SC_ROW_CLEAR_CTRL_RESET_InLow,
  input  logic                                SC_ROW_CLEAR_CTRL_start_In,
  input  logic                                SC_ROW_CLEAR_CTRL_wr_In,
  input  logic [$clog2(NUMBER_ROWS)-1:0]      SC_ROW_CLEAR_CTRL_wrAddr_InBus,
  input  logic [NUMBER_DATAWIDTH-1:0]         SC_ROW_CLEAR_CTRL_wrData_InBus,
  input  logic [$clog2(NUMBER_ROWS)-1:0]      SC_ROW_CLEAR_CTRL_rdAddr_InBus,
  output logic [NUMBER_DATAWIDTH-1:0]         SC_ROW_CLEAR_CTRL_rdData_OutBus,
  output logic [NUMBER_DATAWIDTH-1:0]         SC_ROW_CLEAR_CTRL_row_OutBus,
  input  logic                                SC_ROW_CLEAR_CTRL_cmp_In,
  output logic                                SC_ROW_CLEAR_CTRL_busy_Out,
  output logic                                SC_ROW_CLEAR_CTRL_done_Out,
  output logic [$clog2(NUMBER_ROWS+1)-1:0]    SC_ROW_CLEAR_CTRL_cleared_OutBus
);

  localparam int ADDR_W = $clog2(NUMBER_ROWS);
  localparam int CNT_W  = $clog2(NUMBER_ROWS + 1);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUMBER_ROWS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

  state_t                      state, stateNext;
  logic [NUMBER_DATAWIDTH-1:0] matrix [NUMBER_ROWS];
  logic [ADDR_W-1:0]           rowIdx;
  logic [CNT_W-1:0]            clearCnt;
  logic [CNT_W-1:0]            clearedReg;
  logic [NUMBER_DATAWIDTH-1:0] rowUnderTest;
  logic                        rowFull;

  // The external comparator also matches all-zero rows; bit 0 rejects that case.
  assign rowUnderTest = (state == SCAN) ? matrix[rowIdx] : '0;
  assign rowFull      = SC_ROW_CLEAR_CTRL_cmp_In && rowUnderTest[0];

  assign SC_ROW_CLEAR_CTRL_row_OutBus     = rowUnderTest;
  assign SC_ROW_CLEAR_CTRL_rdData_OutBus  = matrix[SC_ROW_CLEAR_CTRL_rdAddr_InBus];
  assign SC_ROW_CLEAR_CTRL_cleared_OutBus = clearedReg;

  // NOTE: non-blocking assignments in clocked blocks so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge SC_ROW_CLEAR_CTRL_CLOCK_50 or negedge SC_ROW_CLEAR_CTRL_RESET_InLow) begin
    if (!SC_ROW_CLEAR_CTRL_RESET_InLow) state <= IDLE;
    else                                state <= stateNext;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    stateNext                 = state;
    SC_ROW_CLEAR_CTRL_busy_Out = 1'b0;
    SC_ROW_CLEAR_CTRL_done_Out = 1'b0;
    unique case (state)
      IDLE:  if (SC_ROW_CLEAR_CTRL_start_In) stateNext = SCAN;
      SCAN: begin
        SC_ROW_CLEAR_CTRL_busy_Out = 1'b1;
        if (rowFull)                 stateNext = SHIFT;
        else if (rowIdx == LAST_ROW) stateNext = DONE;
      end
      SHIFT: begin
        SC_ROW_CLEAR_CTRL_busy_Out = 1'b1;
        stateNext                  = SCAN;
      end
      DONE: begin
        SC_ROW_CLEAR_CTRL_busy_Out = 1'b1;
        SC_ROW_CLEAR_CTRL_done_Out = 1'b1;
        stateNext                  = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: the matrix is a small flop array that must read as zero after reset,
  // so it is reset like any other register rather than inferred as RAM.
  always_ff @(posedge SC_ROW_CLEAR_CTRL_CLOCK_50 or negedge SC_ROW_CLEAR_CTRL_RESET_InLow) begin
    if (!SC_ROW_CLEAR_CTRL_RESET_InLow) begin
      rowIdx     <= '0;
      clearCnt   <= '0;
      clearedReg <= '0;
      for (int i = 0; i < NUMBER_ROWS; i++) matrix[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (SC_ROW_CLEAR_CTRL_wr_In)
            matrix[SC_ROW_CLEAR_CTRL_wrAddr_InBus] <= SC_ROW_CLEAR_CTRL_wrData_InBus;
          if (SC_ROW_CLEAR_CTRL_start_In) begin
            rowIdx   <= '0;
            clearCnt <= '0;
          end
        end
        SCAN: begin
          if (!rowFull && rowIdx != LAST_ROW) rowIdx <= rowIdx + ADDR_W'(1);
        end
        SHIFT: begin
          // Rows above the cleared one drop by one; the top row refills empty.
          for (int i = 0; i < NUMBER_ROWS - 1; i++)
            if (i >= int'(rowIdx)) matrix[i] <= matrix[i+1];
          matrix[NUMBER_ROWS-1] <= '0;
          clearCnt <= clearCnt + CNT_W'(1);
        end
        DONE: clearedReg <= clearCnt;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_row_clear_ctrl.sv
// Randomized scoreboard bench for sc_row_clear_ctrl: stimulus pushes the
// expected pass result, a monitor pops it when done_Out pulses.
module tb_sc_row_clear_ctrl;

  localparam int R = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, wr = 1'b0;
  logic [2:0] wrAddr = '0, stimAddr = '0, monAddr = '0, rdAddr;
  logic       monRd = 1'b0;
  logic [7:0] wrData = '0, rdData, rowOut;
  logic       cmp, busy, done;
  logic [3:0] cleared;

  sc_row_clear_ctrl dut (
    .SC_ROW_CLEAR_CTRL_CLOCK_50      (clk),
    .SC_ROW_CLEAR_CTRL_RESET_InLow   (rst_n),
    .SC_ROW_CLEAR_CTRL_start_In      (start),
    .SC_ROW_CLEAR_CTRL_wr_In         (wr),
    .SC_ROW_CLEAR_CTRL_wrAddr_InBus  (wrAddr),
    .SC_ROW_CLEAR_CTRL_wrData_InBus  (wrData),
    .SC_ROW_CLEAR_CTRL_rdAddr_InBus  (rdAddr),
    .SC_ROW_CLEAR_CTRL_rdData_OutBus (rdData),
    .SC_ROW_CLEAR_CTRL_row_OutBus    (rowOut),
    .SC_ROW_CLEAR_CTRL_cmp_In        (cmp),
    .SC_ROW_CLEAR_CTRL_busy_Out      (busy),
    .SC_ROW_CLEAR_CTRL_done_Out      (done),
    .SC_ROW_CLEAR_CTRL_cleared_OutBus(cleared)
  );

  always #5 clk = ~clk;

  // External row comparator: all-ones or all-zeros.
  assign cmp    = (rowOut == 8'hFF) || (rowOut == 8'h00);
  assign rdAddr = monRd ? monAddr : stimAddr;

  int checks = 0, errors = 0;
  int cyc = 0;
  int passesSeen = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [63:0] rows;
    logic [3:0]  n;
    logic [31:0] doneCyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model[R];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic doWrite(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    wr = 1'b1; wrAddr = a; wrData = d;
    model[a] = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic loadAll(input logic [63:0] rows);
    for (int r = 0; r < R; r++) doWrite(3'(r), rows[r*8 +: 8]);
  endtask

  // Reference: walk rows bottom-up; a full row vanishes and an empty row
  // appears on top; each clear costs SCAN+SHIFT, each row visit one SCAN.
  task automatic runPass(input bit noise, input bit withWr,
                         input logic [2:0] a, input logic [7:0] d);
    logic [7:0] q[$];
    int   n, idx, seen;
    bit   ok;
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    if (withWr) begin
      wr = 1'b1; wrAddr = a; wrData = d;
      model[a] = d;
    end
    q = {};
    for (int r = 0; r < R; r++) q.push_back(model[r]);
    n = 0; idx = 0;
    while (idx < R) begin
      if (q[idx] == 8'hFF) begin
        q.delete(idx);
        q.push_back(8'h00);
        n++;
      end else idx++;
    end
    for (int r = 0; r < R; r++) begin
      model[r] = q[r];
      e.rows[r*8 +: 8] = q[r];
    end
    e.n = 4'(n);
    @(posedge clk); #1;
    start = 1'b0; wr = 1'b0;
    e.doneCyc = 32'(cyc + 9 + 2*n);
    sb.push_back(e);
    if (noise) begin
      repeat (5) begin
        @(negedge clk);
        start = 1'($urandom); wr = 1'($urandom);
        wrAddr = 3'($urandom); wrData = 8'($urandom);
      end
      @(negedge clk);
      start = 1'b0; wr = 1'b0;
    end
    seen = passesSeen; ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = (passesSeen != seen);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL pass_timeout actual=no_done expected=done");
      sb.delete();
    end
  endtask

  // Monitor: latency, one-cycle pulse, count and matrix for each pass.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=1 expected=0");
        end else begin
          e = sb.pop_front();
          check("done_latency", 64'(cyc + 1), 64'(e.doneCyc));
          @(negedge clk);
          check("done_one_cycle", 64'(done), 64'd0);
          check("busy_after_done", 64'(busy), 64'd0);
          check("cleared_count", 64'(cleared), 64'(e.n));
          monRd = 1'b1;
          for (int r = 0; r < R; r++) begin
            monAddr = 3'(r); #1;
            check($sformatf("row%0d", r), 64'(rdData), 64'(e.rows[r*8 +: 8]));
          end
          monRd = 1'b0;
          passesSeen++;
        end
      end
    end
  end

  task automatic checkAllZero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_row_out"}, 64'(rowOut), 64'd0);
    check({tag, "_cleared"}, 64'(cleared), 64'd0);
    for (int r = 0; r < R; r++) begin
      stimAddr = 3'(r); #0.1;
      check($sformatf("%s_row%0d", tag, r), 64'(rdData), 64'd0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] rows;
    bit ok;
    for (int r = 0; r < R; r++) model[r] = 8'h00;
    #12;
    checkAllZero("reset");
    @(negedge clk); rst_n = 1'b1;

    // All empty: eight scans, nothing cleared.
    runPass(1'b0, 1'b0, 3'd0, 8'h00);
    // Bottom full, next partial.
    loadAll(64'h0000_0000_0000_0FFF);
    runPass(1'b0, 1'b0, 3'd0, 8'h00);
    // Every row full.
    loadAll({8{8'hFF}});
    runPass(1'b0, 1'b0, 3'd0, 8'h00);
    // Two adjacent full rows with a mixed row above, untouched rows below.
    loadAll(64'h0000_0081_FFFF_3C5A);
    runPass(1'b0, 1'b0, 3'd0, 8'h00);
    // Same pattern with writes and starts hammered while busy.
    loadAll(64'h0000_0081_FFFF_3C5A);
    runPass(1'b1, 1'b0, 3'd0, 8'h00);
    // Write and start in the same cycle: the pass sees the new row.
    runPass(1'b0, 1'b1, 3'd0, 8'hFF);

    for (int p = 0; p < 12; p++) begin
      for (int r = 0; r < R; r++)
        rows[r*8 +: 8] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
      loadAll(rows);
      runPass(1'($urandom), 1'($urandom), 3'($urandom), ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom));
    end

    // Leave a nonzero count, then abort a pass during SHIFT.
    loadAll({8{8'hFF}});
    runPass(1'b0, 1'b0, 3'd0, 8'h00);
    loadAll(64'h0000_0000_1234_56FF);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = busy && (rowOut == 8'h00);
    end
    check("reached_shift", 64'(ok), 64'd1);
    #1 rst_n = 1'b0;
    #1 checkAllZero("abort");
    for (int r = 0; r < R; r++) model[r] = 8'h00;
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    loadAll(64'h00FF_0000_FF00_FF01);
    runPass(1'b0, 1'b0, 3'd0, 8'h00);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_row_clear_ctrl.md
SC_ROW_CLEAR_CTRL -- requirements
Module: sc_row_clear_ctrl

Interface
REQ-001 Parameters SHALL be: NUMBER_DATAWIDTH, 8, row width in bits; NUMBER_ROWS, 8, matrix depth (row 0 = bottom).
REQ-002 SC_ROW_CLEAR_CTRL_CLOCK_50  input  1  single system clock; all state changes on its rising edge.
REQ-003 SC_ROW_CLEAR_CTRL_RESET_InLow  input  1  asynchronous, active-low reset.
REQ-004 SC_ROW_CLEAR_CTRL_start_In  input  1  request one scan/clear pass; sampled in IDLE only.
REQ-005 SC_ROW_CLEAR_CTRL_wr_In  input  1  matrix row write enable; honoured in IDLE only.
REQ-006 SC_ROW_CLEAR_CTRL_wrAddr_InBus  input  3  row index for write.
REQ-007 SC_ROW_CLEAR_CTRL_wrData_InBus  input  8  row data for write.
REQ-008 SC_ROW_CLEAR_CTRL_rdAddr_InBus  input  3  row index for combinational read.
REQ-009 SC_ROW_CLEAR_CTRL_rdData_OutBus  output  8  matrix row at rdAddr, combinational, valid in every state.
REQ-010 SC_ROW_CLEAR_CTRL_row_OutBus  output  8  row under test, driven to the row comparator input.
REQ-011 SC_ROW_CLEAR_CTRL_cmp_In  input  1  comparator result (1 = row all-ones or all-zeros), combinational from row_OutBus.
REQ-012 SC_ROW_CLEAR_CTRL_busy_Out  output  1  high in SCAN, SHIFT, DONE.
REQ-013 SC_ROW_CLEAR_CTRL_done_Out  output  1  one-cycle pulse at end of pass.
REQ-014 SC_ROW_CLEAR_CTRL_cleared_OutBus  output  4  rows cleared in the last pass.

Function
REQ-015 The block SHALL hold an 8x8 register matrix plus a 3-bit row index and 4-bit clear counter.
REQ-016 FSM states SHALL be IDLE, SCAN, SHIFT, DONE.
REQ-017 IDLE: wr_In=1 SHALL write wrData into row wrAddr at the clock edge; start_In=1 SHALL clear index and counter and enter SCAN; if both are high, the write SHALL take effect and SCAN SHALL begin the next cycle on the updated matrix.
REQ-018 row_OutBus SHALL equal matrix[index] in SCAN and 8'h00 in all other states.
REQ-019 Full row SHALL be cmp_In=1 AND row_OutBus[0]=1 (qualifies out the all-zero match).
REQ-020 SCAN, full row: go to SHIFT, index unchanged.
REQ-021 SCAN, not full, index<7: index+1, stay in SCAN; index=7: go to DONE.
REQ-022 SHIFT (one cycle): rows index..6 SHALL take rows index+1..7, row 7 SHALL become 8'h00, counter SHALL increment, return to SCAN at the same index.
REQ-023 DONE SHALL assert done_Out for exactly one cycle, load cleared_OutBus from the counter, then return to IDLE.
REQ-024 Latency: start sampled at edge k with n full rows -> done_Out high in cycle k+9+2n; max n=8 (counter never wraps).
REQ-025 start_In and wr_In SHALL be ignored outside IDLE; matrix is modified only by writes and SHIFT.
REQ-026 cleared_OutBus SHALL hold its value until the next DONE.

Reset
REQ-027 RESET_InLow=0 SHALL asynchronously force IDLE, index=0, counter=0, all matrix rows=8'h00, cleared_OutBus=0, done_Out=0, busy_Out=0, row_OutBus=8'h00.
REQ-028 Reset asserted mid-pass SHALL abort immediately with no done_Out pulse; operation resumes on the first clock edge after release.

Verification
REQ-029 Bench SHALL cover: all rows 8'h00, start -> 8 SCAN cycles, done_Out at k+9, cleared_OutBus=0, matrix unchanged.
REQ-030 Bench SHALL cover: row0=FF, row1=0F, others 00 -> done at k+11, cleared=1, row0=0F, rows1..7=00.
REQ-031 Bench SHALL cover: rows0..7 all FF -> done at k+25, cleared=8, all rows 00.
REQ-032 Bench SHALL cover: row2=FF, row3=FF, row4=81 -> cleared=2, row2=81, rows3..7=00, row0/row1 unchanged.
REQ-033 Bench SHALL cover: write and start attempted while busy -> ignored, matrix and result as in a clean pass.
REQ-034 Bench SHALL cover: reset pulled low during SHIFT -> all outputs and matrix 0 asynchronously, no done_Out pulse.
